mem_arb: RTL
============

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 The module SHALL take one clock; reset is asynchronous and active-high.
REQ-002 Parameter: STARVE_MAX, default 4, consecutive data grants allowed while an instruction request waits.
REQ-003 Parameter: TIMEOUT, default 15, cycles in a grant state without ACCESS before abort (see Configuration).
REQ-004 Ports SHALL be exactly:
  CLK       in   1   system clock, rising edge
  RST       in   1   asynchronous reset, active-high
  iREN      in   1   instruction read request
  iaddr     in   32  instruction byte address
  iload     out  32  instruction read data
  iwait     out  1   instruction requestor must hold
  dREN      in   1   data read request
  dWEN      in   1   data write request
  daddr     in   32  data byte address
  dstore    in   32  data write data
  dload     out  32  data read data
  dwait     out  1   data requestor must hold
  ramREN    out  1   RAM read enable
  ramWEN    out  1   RAM write enable
  ramaddr   out  32  RAM address
  ramstore  out  32  RAM write data
  ramload   in   32  RAM read data
  ramstate  in   2   ramstate_t from cpu_types_pkg: FREE, BUSY, ACCESS, ERROR
  arb_err   out  1   one-cycle abort pulse

Function
REQ-005 The FSM SHALL have states IDLE, IGNT, DGNT, registered on CLK.
REQ-006 In IDLE, a data request (dREN|dWEN) SHALL move to DGNT if iREN=0 or starve_cnt<STARVE_MAX; otherwise an iREN SHALL move to IGNT; otherwise remain in IDLE.
REQ-007 In IDLE, ramREN=ramWEN=0, ramaddr=0, ramstore=0.
REQ-008 In IGNT, the RAM outputs SHALL be ramREN=iREN, ramWEN=0, ramaddr=iaddr, ramstore=0, combinationally from the live inputs.
REQ-009 In DGNT, the RAM outputs SHALL be ramaddr=daddr and ramstore=dstore; if dWEN=1 then ramWEN=1 and ramREN=0 (write wins over a simultaneous dREN); else ramREN=dREN.
REQ-010 iload and dload SHALL be ramload while the matching grant state is active, and 0 otherwise.
REQ-011 iwait SHALL be 1 when iREN=1, except in IGNT while ramstate==ACCESS; dwait SHALL follow the same rule using dREN|dWEN and DGNT.
REQ-012 When ramstate==ACCESS in a grant state, the transfer SHALL complete that cycle and the FSM SHALL return to IDLE.
REQ-013 Minimum latency SHALL be: request seen in IDLE at cycle 0, grant at cycle 1, wait low at cycle 1 if the RAM reports ACCESS at cycle 1.
REQ-014 If the granted requestor deasserts its request before ACCESS, the FSM SHALL abort to IDLE without an arb_err pulse.
REQ-015 If ramstate==ERROR in a grant state, the FSM SHALL pulse arb_err for one cycle, keep the wait signal high, and return to IDLE.
REQ-016 starve_cnt (3 bits, saturating at STARVE_MAX) SHALL increment on each data completion while iREN=1, clear to 0 on any instruction completion, and clear to 0 on a data completion with iREN=0.

Reset
REQ-017 While RST=1, the FSM SHALL be IDLE, starve_cnt=0, timeout counter=0, arb_err=0, and all RAM outputs 0.
REQ-018 Reset asserted mid-transfer SHALL drop all RAM outputs combinationally in the same cycle; the in-flight access is lost.

Configuration
REQ-019 Macro MEM_ARB_TIMEOUT_EN defined: a 4-bit counter SHALL count cycles spent in a grant state without ACCESS; when it reaches TIMEOUT, arb_err SHALL pulse, the FSM SHALL return to IDLE, and the counter SHALL clear; it also clears on entering IDLE.
REQ-020 Macro MEM_ARB_TIMEOUT_EN undefined: no counter SHALL exist, grants SHALL wait indefinitely, and arb_err SHALL be driven only by ERROR.

Verification
REQ-021 iREN=1, iaddr=0x40, RAM at zero latency -> ramREN=1 and ramaddr=0x40 at cycle 1; iwait=0 at cycle 1; iload=RAM word.
REQ-022 iREN and dWEN rise together, daddr=0x80, dstore=0x12345678 -> DGNT first, ramWEN=1, then IGNT; iwait stays high until its own ACCESS.
REQ-023 iREN held, 5 back-to-back data reads, STARVE_MAX=4 -> the fifth arbitration grants IGNT; starve_cnt=0 after the instruction completes.
REQ-024 ramstate forced ERROR during DGNT -> arb_err=1 for exactly 1 cycle, dwait=1, FSM in IDLE the next cycle.
REQ-025 With MEM_ARB_TIMEOUT_EN and ramstate held BUSY -> arb_err pulses 15 cycles after grant; RST pulsed mid-DGNT -> ramWEN=0 immediately.

Source files
------------

// File: rtl/mem_arb.sv
// mem_arb: shares one RAM port between an instruction read requestor and a
// data read/write requestor. Data wins arbitration unless it has already been
// granted STARVE_MAX times in a row while an instruction fetch was waiting.
// Build macro MEM_ARB_TIMEOUT_EN adds a grant timeout: after TIMEOUT grant
// cycles without ACCESS the grant is aborted with an arb_err pulse.
// Handshake: a requestor raises its request with stable operands and holds
// them while its wait output is high; the transfer completes in the cycle
// its wait is low (RAM reports ACCESS). Dropping a request while granted
// abandons it silently.

package cpu_types_pkg;
   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;
endpackage

module mem_arb
   import cpu_types_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        iwait,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dwait,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  ramstate_t   ramstate,
   output logic        arb_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } state_t;

   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   // The starvation counter is 3 bits and the timeout counter 4 bits wide.
   if (STARVE_MAX < 1 || STARVE_MAX > 7 || TIMEOUT < 1 || TIMEOUT > 15) begin : g_param_check
      $error("mem_arb: STARVE_MAX must be 1..7 and TIMEOUT must be 1..15");
   end

   state_t     state;
   state_t     next_state;
   logic [2:0] starve_cnt;
   logic [2:0] starve_next;
   logic       d_req;
   logic       i_done;
   logic       d_done;
   logic       tmo;

   assign d_req = dREN | dWEN;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [3:0] TMO_LIM = 4'(TIMEOUT);
   logic [3:0] tmo_cnt;

   // Count grant cycles without ACCESS; cleared in IDLE and on every return to IDLE.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         tmo_cnt <= '0;
      else if (state == IDLE || next_state == IDLE)
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + 4'd1;
   end

   assign tmo = (state != IDLE) && (tmo_cnt == TMO_LIM);
`else
   assign tmo = 1'b0;
`endif

   // State and starvation counter registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         state      <= next_state;
         starve_cnt <= starve_next;
      end
   end

   // Starvation count: data completions while a fetch waits, saturating.
   always_comb begin
      starve_next = starve_cnt;
      if (i_done)
         starve_next = '0;
      else if (d_done) begin
         if (!iREN)
            starve_next = '0;
         else if (starve_cnt < STARVE_LIM)
            starve_next = starve_cnt + 3'd1;
      end
   end

   // Arbitration next state plus RAM and requestor output muxing.
   always_comb begin
      next_state = state;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      iload      = '0;
      dload      = '0;
      iwait      = iREN;
      dwait      = d_req;
      arb_err    = 1'b0;
      i_done     = 1'b0;
      d_done     = 1'b0;
      case (state)
         IDLE: begin
            if (d_req && (!iREN || (starve_cnt < STARVE_LIM)))
               next_state = DGNT;
            else if (iREN)
               next_state = IGNT;
         end
         IGNT: begin
            ramREN  = iREN;
            ramaddr = iaddr;
            iload   = ramload;
            if (!iREN)
               next_state = IDLE;
            else if (ramstate == ACCESS) begin
               iwait      = 1'b0;
               i_done     = 1'b1;
               next_state = IDLE;
            end else if (ramstate == ERROR || tmo) begin
               arb_err    = 1'b1;
               next_state = IDLE;
            end
         end
         DGNT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            dload    = ramload;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            if (!d_req)
               next_state = IDLE;
            else if (ramstate == ACCESS) begin
               dwait      = 1'b0;
               d_done     = 1'b1;
               next_state = IDLE;
            end else if (ramstate == ERROR || tmo) begin
               arb_err    = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
      // Reset kills any in-flight access immediately, not at the next edge.
      if (RST) begin
         next_state = IDLE;
         ramREN     = 1'b0;
         ramWEN     = 1'b0;
         ramaddr    = '0;
         ramstore   = '0;
         iload      = '0;
         dload      = '0;
         arb_err    = 1'b0;
         i_done     = 1'b0;
         d_done     = 1'b0;
      end
   end

endmodule
